// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan display driver: scan FSM state
// encoding, segment bit order and the active-low hex font.
package seg7_pkg;

  // Scan FSM states: dark, anodes-off guard interval, digit driven
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Segment bit order on the seg bus, MSB first: {g,f,e,d,c,b,a}
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  // All segments dark (active-low)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low hex font, 0-F, with lowercase b and d
  localparam seg_bits_t HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Font table lookup
  always_comb begin
    seg = HEX_FONT[nibble];
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment display driver. Advances one digit on every
// edge of the divided scan clock, blanks the anodes for BLANK_CYC cycles
// around each digit change and latches the displayed value once per frame.
// Optional build macro SEG7_LZ_BLANK_EN suppresses leading-zero digits.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                scan_clk,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_start
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int BCNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  scan_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                scan_q;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_start_q, frame_start_d;

  logic                tick;
  logic                wrap;
  logic [IDX_W-1:0]    idx_next;
  logic [3:0]          nib_d;
  logic                dp_sel;
  logic                show_d;
  logic                lz_blank;
  logic [6:0]          font_seg;

  // Scan FSM next state: digit stepping, blank timing and per-frame latch
  always_comb begin
    tick          = scan_clk ^ scan_q;
    wrap          = (idx_q == IDX_LAST);
    idx_next      = wrap ? '0 : idx_q + 1'b1;
    state_d       = state_q;
    idx_d         = idx_q;
    bcnt_d        = bcnt_q;
    shadow_val_d  = shadow_val_q;
    shadow_dp_d   = shadow_dp_q;
    frame_start_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          shadow_val_d  = value;
          shadow_dp_d   = dp_in;
          frame_start_d = 1'b1;
          idx_d         = '0;
          bcnt_d        = '0;
          state_d       = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
        end
        ST_BLANK: begin
          if (tick) begin
            idx_d  = idx_next;
            bcnt_d = '0;
            if (wrap) begin
              shadow_val_d  = value;
              shadow_dp_d   = dp_in;
              frame_start_d = 1'b1;
            end
          end else if (bcnt_q == BCNT_LAST) begin
            state_d = ST_SHOW;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (tick) begin
            idx_d   = idx_next;
            bcnt_d  = '0;
            state_d = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
            if (wrap) begin
              shadow_val_d  = value;
              shadow_dp_d   = dp_in;
              frame_start_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  // Font lookup on the nibble that will be shown after this edge
  seg7_hex_decode u_decode (
    .nibble (nib_d),
    .seg    (font_seg)
  );

  // Output decode from next-state values so outputs align with state entry
  always_comb begin
    nib_d  = '0;
    dp_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_d  = shadow_val_d[4*i +: 4];
        dp_sel = shadow_dp_d[i];
      end
    end
`ifdef SEG7_LZ_BLANK_EN
    begin
      logic [IDX_W-1:0] msd;
      msd = '0;
      for (int i = 1; i < DIGITS; i++) begin
        if (shadow_val_d[4*i +: 4] != 4'h0) begin
          msd = IDX_W'(i);
        end
      end
      lz_blank = (idx_d > msd);
    end
`else
    lz_blank = 1'b0;
`endif
    show_d = (state_d == ST_SHOW);
    an_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (show_d && (idx_d == IDX_W'(i))) begin
        an_d[i] = 1'b0;
      end
    end
    seg_d = (show_d && !lz_blank) ? font_seg : SEG_OFF;
    dp_d  = show_d ? ~dp_sel : 1'b1;
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      bcnt_q        <= '0;
      scan_q        <= 1'b0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bcnt_q        <= bcnt_d;
      scan_q        <= scan_clk;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (DIGITS=4, BLANK_CYC=2). Stimulus pushes
// the expected output-change events with their cycle numbers; a monitor pops
// one entry every time {an, seg, dp, frame_start} changes.
module tb_seg7_scan;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } ev_t;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic        scan_clk;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int          cyc;
  int          n_checks;
  int          n_fail;
  bit          mon_en;
  logic [12:0] prev_out;
  ev_t         exp_q[$];

  seg7_scan #(
    .DIGITS    (4),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .scan_clk    (scan_clk),
    .value       (value),
    .dp_in       (dp_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // Free-running system clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at a negedge, cyc equals the number of the preceding posedge
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the run always ends
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d, required finish by cycle 216", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_ev(input int c, input logic [3:0] a, input logic [6:0] s,
                           input logic d, input logic f);
    ev_t e;
    e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.fs = f;
    exp_q.push_back(e);
  endtask

  // Toggle scan_clk at negedge c and expect blank at c+1, digit lit at c+3
  task automatic applyStimulus(input int c, input logic [3:0] a, input logic [6:0] s,
                               input logic d, input logic f);
    at_cycle(c);
    scan_clk = ~scan_clk;
    expect_ev(c + 1, 4'hF, 7'h7F, 1'b1, f);
    if (f) expect_ev(c + 2, 4'hF, 7'h7F, 1'b1, 1'b0);
    expect_ev(c + 3, a, s, d, 1'b0);
  endtask

  task automatic check_value(input string name, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Compare one observed output change against the next scoreboard entry
  task automatic checkOutput();
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL unexpected_change: cyc=%0d an=%b seg=%h dp=%b fs=%b, expected no change",
               cyc, an, seg, dp, frame_start);
    end else begin
      e = exp_q.pop_front();
      if (cyc != e.cyc || an !== e.an || seg !== e.seg || dp !== e.dp || frame_start !== e.fs) begin
        n_fail++;
        $display("[TB] FAIL output_event: got cyc=%0d an=%b seg=%h dp=%b fs=%b, expected cyc=%0d an=%b seg=%h dp=%b fs=%b",
                 cyc, an, seg, dp, frame_start, e.cyc, e.an, e.seg, e.dp, e.fs);
      end
    end
  endtask

  // Monitor: every change of the output tuple consumes one expected event
  always @(negedge clk) begin
    if (mon_en && ({an, seg, dp, frame_start} !== prev_out)) begin
      prev_out = {an, seg, dp, frame_start};
      checkOutput();
    end
  end

  // Directed stimulus with hand-computed expected events
  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    prev_out = {4'hF, 7'h7F, 1'b1, 1'b0};
    rst      = 1'b1;
    enable   = 1'b1;
    scan_clk = 1'b0;
    value    = 16'h1234;
    dp_in    = 4'b0100;

    at_cycle(3);
    check_value("reset_an", {3'b000, an}, 7'h0F);
    check_value("reset_seg", seg, 7'h7F);
    check_value("reset_dp", {6'b0, dp}, 7'h01);
    check_value("reset_frame_start", {6'b0, frame_start}, 7'h00);
    rst    = 1'b0;
    mon_en = 1'b1;
    expect_ev(4, 4'hF, 7'h7F, 1'b1, 1'b1);
    expect_ev(5, 4'hF, 7'h7F, 1'b1, 1'b0);
    expect_ev(6, 4'hE, 7'h19, 1'b1, 1'b0);

    applyStimulus(9,  4'hD, 7'h30, 1'b1, 1'b0);
    applyStimulus(17, 4'hB, 7'h24, 1'b0, 1'b0);
    applyStimulus(25, 4'h7, 7'h79, 1'b1, 1'b0);
    applyStimulus(33, 4'hE, 7'h19, 1'b1, 1'b1);
    applyStimulus(41, 4'hD, 7'h30, 1'b1, 1'b0);
    applyStimulus(49, 4'hB, 7'h24, 1'b0, 1'b0);

    at_cycle(53);
    value = 16'hABCD;
    applyStimulus(57, 4'h7, 7'h79, 1'b1, 1'b0);
    applyStimulus(65, 4'hE, 7'h21, 1'b1, 1'b1);
    applyStimulus(73, 4'hD, 7'h46, 1'b1, 1'b0);
    applyStimulus(81, 4'hB, 7'h03, 1'b0, 1'b0);

    at_cycle(86);
    enable = 1'b0;
    expect_ev(87, 4'hF, 7'h7F, 1'b1, 1'b0);
    at_cycle(90);
    enable = 1'b1;
    expect_ev(91, 4'hF, 7'h7F, 1'b1, 1'b1);
    expect_ev(92, 4'hF, 7'h7F, 1'b1, 1'b0);
    expect_ev(93, 4'hE, 7'h21, 1'b1, 1'b0);

    at_cycle(97);
    scan_clk = ~scan_clk;
    expect_ev(98, 4'hF, 7'h7F, 1'b1, 1'b0);
    at_cycle(98);
    scan_clk = ~scan_clk;
    expect_ev(101, 4'hB, 7'h03, 1'b0, 1'b0);
    applyStimulus(105, 4'h7, 7'h08, 1'b1, 1'b0);
    applyStimulus(113, 4'hE, 7'h21, 1'b1, 1'b1);

    at_cycle(117);
    value = 16'h0050;
    applyStimulus(121, 4'hD, 7'h46, 1'b1, 1'b0);
    applyStimulus(129, 4'hB, 7'h03, 1'b0, 1'b0);
    applyStimulus(137, 4'h7, 7'h08, 1'b1, 1'b0);
    applyStimulus(145, 4'hE, 7'h40, 1'b1, 1'b1);
    applyStimulus(153, 4'hD, 7'h12, 1'b1, 1'b0);
    applyStimulus(161, 4'hB, LZ_SEG, 1'b0, 1'b0);
    at_cycle(165);
    value = 16'h0000;
    applyStimulus(169, 4'h7, LZ_SEG, 1'b1, 1'b0);
    applyStimulus(177, 4'hE, 7'h40, 1'b1, 1'b1);
    applyStimulus(185, 4'hD, LZ_SEG, 1'b1, 1'b0);
    applyStimulus(193, 4'hB, LZ_SEG, 1'b0, 1'b0);
    applyStimulus(201, 4'h7, LZ_SEG, 1'b1, 1'b0);

    at_cycle(206);
    rst = 1'b1;
    expect_ev(207, 4'hF, 7'h7F, 1'b1, 1'b0);
    at_cycle(207);
    rst = 1'b0;
    expect_ev(208, 4'hF, 7'h7F, 1'b1, 1'b1);
    expect_ev(209, 4'hF, 7'h7F, 1'b1, 1'b0);
    expect_ev(210, 4'hE, 7'h40, 1'b1, 1'b0);

    at_cycle(216);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d events outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
